// File: rtl/vpu_wb_addr_queue_v2.sv
// Write-back address queue: holds destination operand addresses from the VPU
// request side and presents them in order to the write-back stage.
module vpu_wb_addr_queue_v2 #(
    parameter int DEPTH_LG2   = 2,
    parameter int ADDR_W      = 8,
    parameter int PUSH_ONCE   = 1,
    parameter int AFULL_THRES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush_i,
    input  logic                 reset_cmd_i,
    input  logic                 valid_i,
    input  logic [ADDR_W-1:0]    waddr_i,
    output logic                 ready_o,
    output logic                 wb_valid_o,
    output logic [ADDR_W-1:0]    wb_waddr_o,
    input  logic                 wb_ready_i,
    output logic [DEPTH_LG2:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 afull_o,
    output logic                 ovf_err_o
);

    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam int PTR_W = DEPTH_LG2 + 1;
    localparam int IDX_W = (DEPTH_LG2 > 0) ? DEPTH_LG2 : 1;

    // Pointers differ only in the wrap bit exactly when the queue is full.
    localparam logic [PTR_W-1:0] FULL_XOR  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_THRES);
    localparam logic [IDX_W-1:0] IDX_MASK  = IDX_W'(DEPTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_HELD = 1'b1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [0:0]        state_q, state_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic              full_s;
    logic              empty_s;
    logic              push_allowed_s;
    logic              push_s;
    logic              pop_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_idx_s;

    assign full_s         = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
    assign empty_s        = (wr_ptr_q == rd_ptr_q);
    assign push_allowed_s = (PUSH_ONCE == 0) || (state_q == S_IDLE);

    // Flush discards any handshake occurring in the same cycle.
    assign push_s   = valid_i && ready_o && !flush_i;
    assign pop_s    = wb_valid_o && wb_ready_i && !flush_i;
    assign wr_idx_s = IDX_W'(wr_ptr_q) & IDX_MASK;
    assign rd_idx_s = IDX_W'(rd_ptr_q) & IDX_MASK;

    assign ready_o    = !full_s && push_allowed_s;
    assign wb_valid_o = !empty_s;
    assign wb_waddr_o = empty_s ? '0 : mem_q[rd_idx_s];
    assign count_o    = wr_ptr_q - rd_ptr_q;
    assign full_o     = full_s;
    assign empty_o    = empty_s;
    assign afull_o    = (count_o >= AFULL_CNT);
    assign ovf_err_o  = ovf_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Single-shot mode: one accepted push arms S_HELD until the command completes.
    always_comb begin
        state_d = state_q;
        if (flush_i || (PUSH_ONCE == 0)) begin
            state_d = S_IDLE;
        end else if ((state_q == S_IDLE) && push_s) begin
            state_d = S_HELD;
        end else if ((state_q == S_HELD) && reset_cmd_i) begin
            state_d = S_IDLE;
        end
    end

    // A push blocked by S_HELD is not an overflow; only a blocked-by-full one is.
    always_comb begin
        ovf_d = ovf_q;
        if (flush_i) begin
            ovf_d = 1'b0;
        end else if (valid_i && full_s && push_allowed_s) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_idx_s] <= waddr_i;
        end
    end

endmodule

// File: tb/tb_vpu_wb_addr_queue_v2.sv
// Self-checking bench for vpu_wb_addr_queue_v2: one single-shot and one
// streaming instance, a vector table for fill/overflow/drain/flush and a scoreboard for wrap.
module tb_vpu_wb_addr_queue_v2;

    typedef struct {
        logic       valid;
        logic [7:0] waddr;
        logic       wbReady;
        logic       flush;
        logic [2:0] expCount;
        logic       expReady;
        logic       expWbValid;
        logic [7:0] expWaddr;
        logic       expFull;
        logic       expAfull;
        logic       expEmpty;
        logic       expOvf;
    } vector_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       onceFlush, onceResetCmd, onceValid, onceReady, onceWbValid, onceWbReady;
    logic [7:0] onceWaddr, onceWbWaddr;
    logic [2:0] onceCount;
    logic       onceFull, onceEmpty, onceAfull, onceOvf;

    logic       strFlush, strResetCmd, strValid, strReady, strWbValid, strWbReady;
    logic [7:0] strWaddr, strWbWaddr;
    logic [2:0] strCount;
    logic       strFull, strEmpty, strAfull, strOvf;

    int checks = 0;
    int errors = 0;
    logic [7:0] sbQueue[$];
    vector_t vecs[$];

    vpu_wb_addr_queue_v2 #(.DEPTH_LG2(2), .ADDR_W(8), .PUSH_ONCE(1), .AFULL_THRES(3)) dutOnce (
        .clk(clk), .rst_n(rst_n), .flush_i(onceFlush), .reset_cmd_i(onceResetCmd),
        .valid_i(onceValid), .waddr_i(onceWaddr), .ready_o(onceReady),
        .wb_valid_o(onceWbValid), .wb_waddr_o(onceWbWaddr), .wb_ready_i(onceWbReady),
        .count_o(onceCount), .full_o(onceFull), .empty_o(onceEmpty),
        .afull_o(onceAfull), .ovf_err_o(onceOvf)
    );

    vpu_wb_addr_queue_v2 #(.DEPTH_LG2(2), .ADDR_W(8), .PUSH_ONCE(0), .AFULL_THRES(3)) dutStream (
        .clk(clk), .rst_n(rst_n), .flush_i(strFlush), .reset_cmd_i(strResetCmd),
        .valid_i(strValid), .waddr_i(strWaddr), .ready_o(strReady),
        .wb_valid_o(strWbValid), .wb_waddr_o(strWbWaddr), .wb_ready_i(strWbReady),
        .count_o(strCount), .full_o(strFull), .empty_o(strEmpty),
        .afull_o(strAfull), .ovf_err_o(strOvf)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vector_t mkVec(input logic v, input logic [7:0] a, input logic r, input logic f,
                                      input logic [2:0] c, input logic rdy, input logic wv,
                                      input logic [7:0] wa, input logic fu, input logic af,
                                      input logic em, input logic ov);
        vector_t t;
        t.valid = v; t.waddr = a; t.wbReady = r; t.flush = f;
        t.expCount = c; t.expReady = rdy; t.expWbValid = wv; t.expWaddr = wa;
        t.expFull = fu; t.expAfull = af; t.expEmpty = em; t.expOvf = ov;
        return t;
    endfunction

    task automatic applyStimulus(input vector_t v);
        @(negedge clk);
        strValid   = v.valid;
        strWaddr   = v.waddr;
        strWbReady = v.wbReady;
        strFlush   = v.flush;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input vector_t v);
        checkVal({tag, " count"},   32'(strCount),   32'(v.expCount));
        checkVal({tag, " ready"},   32'(strReady),   32'(v.expReady));
        checkVal({tag, " wbValid"}, 32'(strWbValid), 32'(v.expWbValid));
        checkVal({tag, " wbWaddr"}, 32'(strWbWaddr), 32'(v.expWaddr));
        checkVal({tag, " full"},    32'(strFull),    32'(v.expFull));
        checkVal({tag, " afull"},   32'(strAfull),   32'(v.expAfull));
        checkVal({tag, " empty"},   32'(strEmpty),   32'(v.expEmpty));
        checkVal({tag, " ovf"},     32'(strOvf),     32'(v.expOvf));
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, " once count"},   32'(onceCount),   32'd0);
        checkVal({tag, " once empty"},   32'(onceEmpty),   32'd1);
        checkVal({tag, " once wbValid"}, 32'(onceWbValid), 32'd0);
        checkVal({tag, " once ovf"},     32'(onceOvf),     32'd0);
        checkVal({tag, " once ready"},   32'(onceReady),   32'd1);
        checkVal({tag, " str count"},    32'(strCount),    32'd0);
        checkVal({tag, " str empty"},    32'(strEmpty),    32'd1);
        checkVal({tag, " str full"},     32'(strFull),     32'd0);
        checkVal({tag, " str afull"},    32'(strAfull),    32'd0);
        checkVal({tag, " str wbValid"},  32'(strWbValid),  32'd0);
        checkVal({tag, " str wbWaddr"},  32'(strWbWaddr),  32'd0);
        checkVal({tag, " str ovf"},      32'(strOvf),      32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        onceFlush = 0; onceResetCmd = 0; onceValid = 0; onceWaddr = 0; onceWbReady = 0;
        strFlush = 0; strResetCmd = 0; strValid = 0; strWaddr = 0; strWbReady = 0;
        #1;
        checkReset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-shot: first push accepted, held valid_i ignored without error.
        @(negedge clk); onceValid = 1; onceWaddr = 8'h11;
        @(posedge clk); #1;
        checkVal("once push wbValid", 32'(onceWbValid), 32'd1);
        checkVal("once push wbWaddr", 32'(onceWbWaddr), 32'h11);
        checkVal("once push count",   32'(onceCount),   32'd1);
        checkVal("once push ready",   32'(onceReady),   32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); onceWaddr = 8'h22;
            @(posedge clk); #1;
            checkVal("once held count", 32'(onceCount), 32'd1);
            checkVal("once held ovf",   32'(onceOvf),   32'd0);
            checkVal("once held ready", 32'(onceReady), 32'd0);
        end
        @(negedge clk); onceResetCmd = 1; onceWaddr = 8'h33;
        @(posedge clk); #1;
        checkVal("once rearm count", 32'(onceCount), 32'd1);
        checkVal("once rearm ready", 32'(onceReady), 32'd1);
        @(negedge clk); onceResetCmd = 0; onceWaddr = 8'h44;
        @(posedge clk); #1;
        checkVal("once second count", 32'(onceCount),   32'd2);
        checkVal("once second ready", 32'(onceReady),   32'd0);
        checkVal("once second head",  32'(onceWbWaddr), 32'h11);
        @(negedge clk); onceValid = 0; onceWbReady = 1;
        @(posedge clk); #1;
        checkVal("once pop head",  32'(onceWbWaddr), 32'h44);
        checkVal("once pop count", 32'(onceCount),   32'd1);
        @(negedge clk); onceWbReady = 0; onceFlush = 1; onceValid = 1;
        @(posedge clk); #1;
        checkVal("once flush count", 32'(onceCount), 32'd0);
        checkVal("once flush empty", 32'(onceEmpty), 32'd1);
        checkVal("once flush ready", 32'(onceReady), 32'd1);
        @(negedge clk); onceFlush = 0; onceValid = 0;

        // Streaming: fill, overflow, drain, full+push+pop, flush with pending handshakes.
        vecs.push_back(mkVec(1, 8'hA0, 0, 0, 3'd1, 1, 1, 8'hA0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 8'hA1, 0, 0, 3'd2, 1, 1, 8'hA0, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 8'hA2, 0, 0, 3'd3, 1, 1, 8'hA0, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 8'hA3, 0, 0, 3'd4, 0, 1, 8'hA0, 1, 1, 0, 0));
        vecs.push_back(mkVec(1, 8'hA4, 0, 0, 3'd4, 0, 1, 8'hA0, 1, 1, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 0, 0, 3'd4, 0, 1, 8'hA0, 1, 1, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 3'd3, 1, 1, 8'hA1, 0, 1, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 3'd2, 1, 1, 8'hA2, 0, 0, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 3'd1, 1, 1, 8'hA3, 0, 0, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 3'd0, 1, 0, 8'h00, 0, 0, 1, 1));
        vecs.push_back(mkVec(1, 8'hB0, 0, 0, 3'd1, 1, 1, 8'hB0, 0, 0, 0, 1));
        vecs.push_back(mkVec(1, 8'hB1, 0, 0, 3'd2, 1, 1, 8'hB0, 0, 0, 0, 1));
        vecs.push_back(mkVec(1, 8'hB2, 0, 0, 3'd3, 1, 1, 8'hB0, 0, 1, 0, 1));
        vecs.push_back(mkVec(1, 8'hB3, 0, 0, 3'd4, 0, 1, 8'hB0, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 8'hB4, 1, 0, 3'd3, 1, 1, 8'hB1, 0, 1, 0, 1));
        vecs.push_back(mkVec(1, 8'hB4, 0, 0, 3'd4, 0, 1, 8'hB1, 1, 1, 0, 1));
        vecs.push_back(mkVec(0, 8'h00, 1, 0, 3'd3, 1, 1, 8'hB2, 0, 1, 0, 1));
        vecs.push_back(mkVec(1, 8'hC0, 1, 1, 3'd0, 1, 0, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mkVec(0, 8'h00, 0, 0, 3'd0, 1, 0, 8'h00, 0, 0, 1, 0));
        vecs.push_back(mkVec(1, 8'hC1, 0, 0, 3'd1, 1, 1, 8'hC1, 0, 0, 0, 0));
        vecs.push_back(mkVec(0, 8'h00, 0, 1, 3'd0, 1, 0, 8'h00, 0, 0, 1, 0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i]);
        end

        // Wrap: steady push+pop at occupancy 2, scoreboard tracks order.
        @(negedge clk); strFlush = 0; strWbReady = 0; strValid = 1; strWaddr = 8'hF0;
        sbQueue.push_back(8'hF0);
        @(negedge clk); strWaddr = 8'hF1;
        sbQueue.push_back(8'hF1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkVal("wrap count",   32'(strCount),   32'd2);
            checkVal("wrap wbValid", 32'(strWbValid), 32'd1);
            checkVal("wrap full",    32'(strFull),    32'd0);
            checkVal("wrap head",    32'(strWbWaddr), 32'(sbQueue.pop_front()));
            strValid = 1; strWaddr = 8'(i); strWbReady = 1;
            sbQueue.push_back(8'(i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkVal("drain wbValid", 32'(strWbValid), 32'd1);
            checkVal("drain head",    32'(strWbWaddr), 32'(sbQueue.pop_front()));
            strValid = 0; strWbReady = 1;
        end
        @(negedge clk);
        checkVal("drain empty", 32'(strEmpty), 32'd1);
        checkVal("drain count", 32'(strCount), 32'd0);
        strWbReady = 0;

        // Asynchronous reset in the middle of a push with two entries queued.
        strValid = 1; strWaddr = 8'h61;
        @(negedge clk); strWaddr = 8'h62;
        @(negedge clk); strWaddr = 8'h63;
        checkVal("pre-reset count", 32'(strCount), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        checkReset("async reset");
        @(negedge clk);
        strValid = 0;
        rst_n = 1'b1;
        @(negedge clk);
        checkVal("post-reset empty", 32'(strEmpty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
